// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, multi-cycle execute hold,
// exception flush with redirect target and a saturating stall counter.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_start,
  input  logic [5:0]  ex_cycles,
  input  logic        excpt_req,
  input  logic [31:0] excpt_vec,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        ex_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULTI = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] HOLD_EX = 6'b001111;
  localparam logic [5:0] HOLD_ID = 6'b000111;

  state_t     state;
  logic [5:0] cnt;

  assign flush = (state == FLUSH);

  always_comb begin
    stall   = '0;
    ex_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (excpt_req) begin
          stall = '0;
        end else if (ex_start && ex_cycles != 6'd0) begin
          stall   = HOLD_EX;
          ex_done = (ex_cycles == 6'd1);
        end else if (stallreq_id) begin
          stall = HOLD_ID;
        end
      end
      MULTI: begin
        stall   = HOLD_EX;
        // an exception on the last cycle aborts, so no completion pulse
        ex_done = (cnt == 6'd0) && !excpt_req;
      end
      FLUSH: stall = '0;
      default: stall = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      new_pc    <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall != 6'd0 && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      unique case (state)
        IDLE: begin
          if (excpt_req) begin
            state  <= FLUSH;
            new_pc <= excpt_vec;
          end else if (ex_start && ex_cycles > 6'd1) begin
            state <= MULTI;
            cnt   <= ex_cycles - 6'd2;
          end
        end
        MULTI: begin
          if (excpt_req) begin
            state  <= FLUSH;
            new_pc <= excpt_vec;
            cnt    <= '0;
          end else if (cnt == 6'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic checked
// against a remaining-cycles model of the pipeline controller.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        ex_start;
  logic [5:0]  ex_cycles;
  logic        excpt_req;
  logic [31:0] excpt_vec;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_done;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  // reference model: cycles of held execute left, pending flush, target
  int          rem;
  bit          flush_m;
  logic [31:0] pc_m;
  int          sc_m;
  bit          done_seen;

  pipe_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stallreq_id(stallreq_id),
    .ex_start   (ex_start),
    .ex_cycles  (ex_cycles),
    .excpt_req  (excpt_req),
    .excpt_vec  (excpt_vec),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .ex_done    (ex_done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rem     = 0;
    flush_m = 0;
    pc_m    = '0;
    sc_m    = 0;
  endtask

  task automatic idle_in();
    stallreq_id = 0;
    ex_start    = 0;
    ex_cycles   = 0;
    excpt_req   = 0;
    excpt_vec   = '0;
  endtask

  task automatic cycle(input bit check);
    logic [5:0] e_stall;
    bit         e_done;
    @(negedge clk);
    e_stall = '0;
    e_done  = 0;
    if (flush_m) begin
      e_stall = '0;
    end else if (rem > 0) begin
      e_stall = 6'b001111;
      e_done  = (rem == 1) && !excpt_req;
    end else if (excpt_req) begin
      e_stall = '0;
    end else if (ex_start && ex_cycles >= 1) begin
      e_stall = 6'b001111;
      e_done  = (ex_cycles == 1);
    end else if (stallreq_id) begin
      e_stall = 6'b000111;
    end
    if (e_done) done_seen = 1;
    if (check) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("flush", 32'(flush), 32'(flush_m));
      chk("new_pc", new_pc, pc_m);
      chk("ex_done", 32'(ex_done), 32'(e_done));
      chk("stall_cnt", 32'(stall_cnt), 32'(sc_m));
    end
    @(posedge clk);
    if (e_stall != 0 && sc_m < 65535) sc_m++;
    if (flush_m) begin
      flush_m = 0;
    end else if (rem > 0) begin
      if (excpt_req) begin
        flush_m = 1;
        pc_m    = excpt_vec;
        rem     = 0;
      end else begin
        rem--;
      end
    end else if (excpt_req) begin
      flush_m = 1;
      pc_m    = excpt_vec;
    end else if (ex_start && ex_cycles >= 1) begin
      rem = int'(ex_cycles) - 1;
    end
    #1;
  endtask

  initial begin
    rst = 0;
    idle_in();
    model_reset();
    done_seen = 0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1;

    // single-cycle load-use hold
    stallreq_id = 1;
    cycle(1);
    idle_in();
    cycle(1);
    chk("id_hold_cnt", 32'(stall_cnt), 32'd1);

    // five-cycle divide
    done_seen = 0;
    ex_start  = 1;
    ex_cycles = 6'd5;
    cycle(1);
    idle_in();
    for (int i = 0; i < 6; i++) cycle(1);
    chk("div5_cnt", 32'(stall_cnt), 32'd6);
    chk("div5_done", 32'(done_seen), 32'd1);

    // exception in the third cycle of a five-cycle op
    done_seen = 0;
    ex_start  = 1;
    ex_cycles = 6'd5;
    cycle(1);
    idle_in();
    cycle(1);
    excpt_req = 1;
    excpt_vec = 32'hBFC00380;
    cycle(1);
    idle_in();
    chk("abort_flush", 32'(flush), 32'h1);
    chk("abort_pc", new_pc, 32'hBFC00380);
    for (int i = 0; i < 4; i++) cycle(1);
    chk("abort_no_done", 32'(done_seen), 32'h0);

    // all requests at once in IDLE
    excpt_req   = 1;
    excpt_vec   = 32'h8000_0180;
    ex_start    = 1;
    ex_cycles   = 6'd7;
    stallreq_id = 1;
    cycle(1);
    idle_in();
    for (int i = 0; i < 3; i++) cycle(1);

    // degenerate op lengths
    ex_start  = 1;
    ex_cycles = 6'd0;
    cycle(1);
    ex_cycles = 6'd1;
    cycle(1);
    ex_cycles = 6'd63;
    cycle(1);
    idle_in();
    for (int i = 0; i < 64; i++) cycle(1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      stallreq_id = ($urandom_range(0, 1) == 1);
      ex_start    = ($urandom_range(0, 4) == 0);
      ex_cycles   = 6'($urandom_range(0, 9));
      excpt_req   = ($urandom_range(0, 29) == 0);
      excpt_vec   = $urandom;
      cycle(1);
    end
    idle_in();

    // asynchronous reset in the middle of a multi-cycle op
    ex_start  = 1;
    ex_cycles = 6'd10;
    cycle(1);
    idle_in();
    cycle(1);
    cycle(1);
    #2;
    rst = 0;
    #1;
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_flush", 32'(flush), 32'h0);
    chk("arst_done", 32'(ex_done), 32'h0);
    chk("arst_pc", new_pc, 32'h0);
    chk("arst_cnt", 32'(stall_cnt), 32'h0);
    model_reset();
    rst = 1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) cycle(1);
    chk("arst_no_done", 32'(done_seen), 32'h0);

    // saturation of the stall counter
    stallreq_id = 1;
    for (int i = 0; i < 65540; i++) cycle(0);
    chk("sat_cnt", 32'(stall_cnt), 32'h0000FFFF);
    cycle(1);
    idle_in();
    cycle(1);
    chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk  in  1  single clock, all state on rising edge.
REQ-002 rst  in  1  reset; asynchronous, active-low.
REQ-003 stallreq_id  in  1  load-use hazard from decode; one-cycle hold request.
REQ-004 ex_start  in  1  execute begins a multi-cycle op (divide); sampled one cycle.
REQ-005 ex_cycles  in  6  total cycles the multi-cycle op occupies execute; valid with ex_start.
REQ-006 excpt_req  in  1  exception raised in memory stage.
REQ-007 excpt_vec  in  32  handler address; valid with excpt_req.
REQ-008 stall  out  6  hold vector, bit0=pc, bit1=if, bit2=id, bit3=ex, bit4=mem, bit5=wb.
REQ-009 flush  out  1  clear all pipeline registers to bubble.
REQ-010 new_pc  out  32  redirect target, meaningful only while flush=1.
REQ-011 ex_done  out  1  last stall cycle of a multi-cycle op.
REQ-012 stall_cnt  out  16  saturating count of cycles with stall nonzero.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, MULTI, FLUSH.
REQ-014 IDLE: excpt_req=1 -> FLUSH, latch excpt_vec into new_pc register; highest priority.
REQ-015 IDLE, no exception, ex_start=1 and ex_cycles>1 -> MULTI, load down-counter cnt with ex_cycles-2.
REQ-016 IDLE, ex_start=1 with ex_cycles of 0 or 1 SHALL cause no state change and no stall beyond this cycle's combinational value.
REQ-017 MULTI: cnt decrements by 1 per cycle; cnt=0 -> IDLE; excpt_req=1 -> FLUSH (aborts op, latches excpt_vec).
REQ-018 MULTI: ex_start SHALL be ignored.
REQ-019 FLUSH: lasts exactly one cycle, then IDLE unconditionally; excpt_req and ex_start in FLUSH ignored.
REQ-020 stall SHALL be combinational from state and inputs, same-cycle.
REQ-021 stall in IDLE: ex_start=1 and ex_cycles>=1 -> 6'b001111; else stallreq_id=1 -> 6'b000111; else 6'b000000.
REQ-022 stall in IDLE with excpt_req=1 SHALL be 6'b000000 regardless of other requests.
REQ-023 stall in MULTI: 6'b001111 (stallreq_id has no additional effect); in FLUSH: 6'b000000.
REQ-024 Total stall length for op with ex_cycles=N>=1 and no exception SHALL be exactly N cycles, starting the ex_start cycle.
REQ-025 flush SHALL equal 1 exactly while state=FLUSH; new_pc holds latched vector, unchanged until next exception.
REQ-026 ex_done SHALL be 1 in MULTI when cnt=0, and in IDLE when ex_start=1 with ex_cycles=1; 0 otherwise; never 1 on abort.
REQ-027 stall_cnt SHALL increment each cycle stall!=0 and saturate at 16'hFFFF.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, cnt=0, new_pc=32'h0, stall_cnt=0; flush=0, ex_done=0 as consequence.
REQ-029 Reset asserted mid-MULTI or mid-FLUSH SHALL abandon the operation with no ex_done or flush afterward.
REQ-030 After rst rises, first rising edge SHALL evaluate inputs normally.

Verification
REQ-031 stallreq_id=1 one cycle in IDLE -> stall=6'b000111 that cycle only, stall_cnt=1.
REQ-032 ex_start=1, ex_cycles=5 -> stall=6'b001111 for exactly 5 cycles, ex_done=1 only in 5th, then stall=0, stall_cnt=5.
REQ-033 ex_cycles=5 op, excpt_req=1 with excpt_vec=32'hBFC00380 in 3rd cycle -> next cycle flush=1, new_pc=32'hBFC00380, stall=0, ex_done never 1.
REQ-034 excpt_req and ex_start and stallreq_id together in IDLE -> stall=0 that cycle, FLUSH next, no MULTI entered.
REQ-035 rst=0 asynchronously mid-MULTI -> stall=0 and all outputs at reset values before next clock edge.
REQ-036 Force continuous stallreq_id for 65540 cycles -> stall_cnt holds 16'hFFFF, no wrap.
